// File: rtl/result_chunk_display.sv
// Captures a result word and steps it onto the LED bank one chunk per button press,
// low chunk first. Reports the sign of the active width and a completion pulse.
module result_chunk_display #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DATA_W-1:0]  result,
  input  logic [1:0]         size_sel,
  input  logic               next,
  output logic [CHUNK_W-1:0] leds,
  output logic [1:0]         chunk_idx,
  output logic               sign,
  output logic               busy,
  output logic               last,
  output logic               done
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [1:0]          size_q, size_n;
  logic [1:0]          idx_n;
  logic [CHUNK_W-1:0]  leds_n;
  logic [CHUNK_W-1:0]  top_chunk;
  logic                sign_n;
  logic                done_n;

  function automatic logic [CHUNK_W-1:0] pick_chunk(input logic [DATA_W-1:0] d,
                                                     input logic [1:0] i);
    case (i)
      2'd0:    return d[CHUNK_W-1:0];
      2'd1:    return d[2*CHUNK_W-1:CHUNK_W];
      2'd2:    return d[3*CHUNK_W-1:2*CHUNK_W];
      default: return d[4*CHUNK_W-1:3*CHUNK_W];
    endcase
  endfunction

  // load takes priority over next so a new result always restarts the display
  always_comb begin
    state_n = state;
    data_n  = data_q;
    size_n  = size_q;
    idx_n   = chunk_idx;
    done_n  = 1'b0;
    if (load) begin
      data_n  = result;
      size_n  = size_sel;
      idx_n   = 2'd0;
      state_n = SHOW;
    end else if (state == SHOW && next) begin
      if (chunk_idx == size_q) begin
        done_n  = 1'b1;
        idx_n   = 2'd0;
        state_n = IDLE;
      end else begin
        idx_n = chunk_idx + 2'd1;
      end
    end
    leds_n    = (state_n == SHOW) ? pick_chunk(data_n, idx_n) : '0;
    top_chunk = pick_chunk(data_n, size_n);
    sign_n    = top_chunk[CHUNK_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      size_q    <= 2'd0;
      chunk_idx <= 2'd0;
      leds      <= '0;
      sign      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      size_q    <= size_n;
      chunk_idx <= idx_n;
      leds      <= leds_n;
      sign      <= sign_n;
      done      <= done_n;
    end
  end

  assign busy = (state == SHOW);
  assign last = busy && (chunk_idx == size_q);

endmodule

// File: tb/tb_result_chunk_display.sv
// Directed-vector bench: each cycle's hand-computed expectation goes into a queue,
// and a monitor pops and compares it just after the clock edge.
module tb_result_chunk_display;

  logic        clk = 1'b0;
  logic        rst, load, next;
  logic [63:0] result;
  logic [1:0]  size_sel;
  logic [15:0] leds;
  logic [1:0]  chunk_idx;
  logic        sign, busy, last, done;

  typedef struct {
    int          vec;
    logic [15:0] leds;
    logic [1:0]  idx;
    logic        sign;
    logic        busy;
    logic        last;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  int   vec_num      = 0;

  result_chunk_display #(.DATA_W(64), .CHUNK_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .result(result), .size_sel(size_sel),
    .next(next), .leds(leds), .chunk_idx(chunk_idx), .sign(sign), .busy(busy),
    .last(last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int vec,
                             input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL vec%0d %s: got %h, expected %h", vec, name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic applyStimulus(input logic r, input logic ld, input logic [63:0] res,
                               input logic [1:0] sz, input logic nx,
                               input logic [15:0] e_leds, input logic [1:0] e_idx,
                               input logic e_sign, input logic e_busy,
                               input logic e_last, input logic e_done);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; result = res; size_sel = sz; next = nx;
    e.vec = vec_num; e.leds = e_leds; e.idx = e_idx; e.sign = e_sign;
    e.busy = e_busy; e.last = e_last; e.done = e_done;
    exp_q.push_back(e);
    vec_num++;
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("leds",      e.vec, 64'(leds),      64'(e.leds));
        checkOutput("chunk_idx", e.vec, 64'(chunk_idx), 64'(e.idx));
        checkOutput("sign",      e.vec, 64'(sign),      64'(e.sign));
        checkOutput("busy",      e.vec, 64'(busy),      64'(e.busy));
        checkOutput("last",      e.vec, 64'(last),      64'(e.last));
        checkOutput("done",      e.vec, 64'(done),      64'(e.done));
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; load = 1'b0; next = 1'b0; result = '0; size_sel = 2'd0;

    // reset, then next pulses in IDLE are ignored
    applyStimulus(1, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 0, 0, 0, 0);

    // full 64-bit walk
    applyStimulus(0, 1, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 16'hCDEF, 2'd0, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'hCDEF, 2'd0, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h89AB, 2'd1, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h89AB, 2'd1, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h4567, 2'd2, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0123, 2'd3, 0, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 0, 0, 0, 0);

    // single 16-bit chunk, sign from bit 15, held after returning to IDLE
    applyStimulus(0, 1, 64'h0000_0000_0000_8001, 2'd0, 0, 16'h8001, 2'd0, 1, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 1, 0, 0, 1);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 1, 0, 0, 0);

    // upper bits set but outside the active width: sign from bit 15 only
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_7FFF, 2'd0, 0, 16'h7FFF, 2'd0, 0, 1, 1, 0);

    // 32-bit value, then load collides with next on the last chunk
    applyStimulus(0, 1, 64'h0000_0000_FFFF_1234, 2'd1, 0, 16'h1234, 2'd0, 1, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'hFFFF, 2'd1, 1, 1, 1, 0);
    applyStimulus(0, 1, 64'h0000_0000_0000_5555, 2'd0, 1, 16'h5555, 2'd0, 0, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 1);

    // 48-bit value, reset mid-display overrides next, then reload
    applyStimulus(0, 1, 64'hAAAA_8000_0000_0001, 2'd2, 0, 16'h0001, 2'd0, 1, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd1, 1, 1, 0, 0);
    applyStimulus(1, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 0);
    applyStimulus(0, 1, 64'hAAAA_8000_0000_0001, 2'd2, 0, 16'h0001, 2'd0, 1, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd1, 1, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h8000, 2'd2, 1, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 1, 0, 0, 1);

    // next held high for three cycles, then the fourth press completes
    applyStimulus(0, 1, 64'h1111_2222_3333_4444, 2'd3, 0, 16'h4444, 2'd0, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h3333, 2'd1, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h2222, 2'd2, 0, 1, 0, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h1111, 2'd3, 0, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h1111, 2'd3, 0, 1, 1, 0);
    applyStimulus(0, 0, 64'h0, 2'd0, 1, 16'h0000, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 64'h0, 2'd0, 0, 16'h0000, 2'd0, 0, 0, 0, 0);

    @(negedge clk);
    checkOutput("queue_drained", vec_num, 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
